cv32e41s_div_issue: RTL and testbench

CV32E41S_DIV_ISSUE -- requirements
Module: cv32e41s_div_issue

---
 rtl/cv32e41s_div_issue.sv | 154 +++++++++++++++
 tb/tb_cv32e41s_div_issue.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_div_issue.sv
// rtl/cv32e41s_div_issue.sv - divide issue stage: holds one operation, drives the divider, buffers the result for writeback
package cv32e41s_div_issue_pkg;
   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_REM  = 2'd2,
      DIV_REMU = 2'd3
   } div_opcode_e;
endpackage

module cv32e41s_div_issue
   import cv32e41s_div_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid_i,
   output logic        id_ready_o,
   input  div_opcode_e id_operator_i,
   input  logic [31:0] id_op_a_i,
   input  logic [31:0] id_op_b_i,
   input  logic [4:0]  id_rd_i,
   input  logic        data_ind_timing_i,
   input  logic        kill_i,
   output logic        div_en_o,
   output logic        div_valid_o,
   output div_opcode_e div_operator_o,
   output logic [31:0] div_op_a_o,
   output logic [31:0] div_op_b_o,
   output logic        div_data_ind_timing_o,
   input  logic        div_valid_i,
   output logic        div_ready_o,
   input  logic        div_ready_i,
   input  logic [31:0] div_result_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [31:0] wb_result_o,
   output logic [4:0]  wb_rd_o,
   output logic [7:0]  div_cycles_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e      state_q, state_d;
   div_opcode_e op_q;
   logic [31:0] op_a_q, op_b_q, result_q;
   logic [4:0]  rd_q, wb_rd_q;
   logic [7:0]  cnt_q, cnt_inc, cycles_q;
   logic        accept, done;

   always_comb begin
      state_d     = state_q;
      id_ready_o  = 1'b0;
      div_valid_o = 1'b0;
      div_en_o    = 1'b0;
      div_ready_o = 1'b0;
      wb_valid_o  = 1'b0;
      accept      = 1'b0;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            id_ready_o = 1'b1;
            if (id_valid_i) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            div_valid_o = 1'b1;
            div_en_o    = 1'b1;
            div_ready_o = 1'b1;
            if (div_valid_i) begin
               done    = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            wb_valid_o = 1'b1;
            if (wb_ready_i) begin
               id_ready_o = 1'b1;
               if (id_valid_i) begin
                  accept  = 1'b1;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A flush overrides everything, including a result arriving this cycle
      if (kill_i) begin
         state_d     = IDLE;
         id_ready_o  = 1'b0;
         div_valid_o = 1'b0;
         div_en_o    = 1'b0;
         div_ready_o = 1'b0;
         wb_valid_o  = 1'b0;
         accept      = 1'b0;
         done        = 1'b0;
      end
   end

   assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= DIV_DIV;
         op_a_q   <= '0;
         op_b_q   <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         wb_rd_q  <= '0;
         cycles_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= id_operator_i;
            op_a_q <= id_op_a_i;
            op_b_q <= id_op_b_i;
            rd_q   <= id_rd_i;
            cnt_q  <= '0;
         end else if (div_valid_o) begin
            cnt_q <= cnt_inc;
         end
         // The completing cycle counts as a BUSY cycle
         if (done) begin
            result_q <= div_result_i;
            wb_rd_q  <= rd_q;
            cycles_q <= cnt_inc;
         end
      end
   end

   assign div_operator_o        = op_q;
   assign div_op_a_o            = op_a_q;
   assign div_op_b_o            = op_b_q;
   assign div_data_ind_timing_o = data_ind_timing_i;
   assign wb_result_o           = result_q;
   assign wb_rd_o               = wb_rd_q;
   assign div_cycles_o          = cycles_q;

   a_op_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (div_valid_o && $past(div_valid_o)) |->
         ($stable(div_operator_o) && $stable(div_op_a_o) && $stable(div_op_b_o)));

   a_wb_after_done: assert property (@(posedge clk) disable iff (!rst_n)
      (wb_valid_o && !$past(wb_valid_o)) |-> $past(done));

   a_div_ready_known: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown(div_ready_i));

endmodule

// File: tb/tb_cv32e41s_div_issue.sv
// tb/tb_cv32e41s_div_issue.sv - randomized bench with a behavioural divider and writeback scoreboard
module tb_cv32e41s_div_issue;
   import cv32e41s_div_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid_i, id_ready_o;
   div_opcode_e id_operator_i;
   logic [31:0] id_op_a_i, id_op_b_i;
   logic [4:0]  id_rd_i;
   logic        data_ind_timing_i, kill_i;
   logic        div_en_o, div_valid_o, div_data_ind_timing_o;
   div_opcode_e div_operator_o;
   logic [31:0] div_op_a_o, div_op_b_o;
   logic        div_valid_i, div_ready_o, div_ready_i;
   logic [31:0] div_result_i;
   logic        wb_valid_o, wb_ready_i;
   logic [31:0] wb_result_o;
   logic [4:0]  wb_rd_o;
   logic [7:0]  div_cycles_o;

   cv32e41s_div_issue dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
      .id_operator_i(id_operator_i), .id_op_a_i(id_op_a_i), .id_op_b_i(id_op_b_i),
      .id_rd_i(id_rd_i), .data_ind_timing_i(data_ind_timing_i), .kill_i(kill_i),
      .div_en_o(div_en_o), .div_valid_o(div_valid_o), .div_operator_o(div_operator_o),
      .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
      .div_data_ind_timing_o(div_data_ind_timing_o),
      .div_valid_i(div_valid_i), .div_ready_o(div_ready_o), .div_ready_i(div_ready_i),
      .div_result_i(div_result_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_result_o(wb_result_o), .wb_rd_o(wb_rd_o), .div_cycles_o(div_cycles_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // RISC-V M-extension division semantics
   function automatic logic [31:0] ref_div(div_opcode_e op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      case (op)
         DIV_DIV:  r = (b == 0) ? 32'hFFFFFFFF :
                       (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'($signed(a) / $signed(b));
         DIV_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         DIV_REM:  r = (b == 0) ? a :
                       (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'($signed(a) % $signed(b));
         default:  r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Divider latency: fixed under data-independent timing, operand dependent otherwise
   function automatic int lat_of(logic dit, div_opcode_e op, logic [31:0] a, logic [31:0] b);
      if (dit) return 34;
      if (a == 32'h12345678 && op == DIV_DIVU) return 300;
      return 1 + int'((a ^ b) % 23);
   endfunction

   // Behavioural divider
   logic       run;
   logic [8:0] dcnt;
   assign div_valid_i  = (run || div_valid_o) &&
                         (int'(dcnt) == lat_of(div_data_ind_timing_o, div_operator_o, div_op_a_o, div_op_b_o) - 1);
   assign div_result_i = ref_div(div_operator_o, div_op_a_o, div_op_b_o);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run  <= 1'b0;
         dcnt <= '0;
      end else if (div_valid_o && !div_valid_i) begin
         run  <= 1'b1;
         dcnt <= dcnt + 9'd1;
      end else begin
         run  <= 1'b0;
         dcnt <= '0;
      end
   end

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic [7:0]  cyc;
   } exp_t;
   exp_t       exp_q[$];
   logic [7:0] last_cyc = 8'd0;
   bit         rnd_wb   = 1'b0;

   function automatic exp_t mk_exp(div_opcode_e op, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                                   logic [31:0] res);
      exp_t e;
      int   l;
      l     = lat_of(data_ind_timing_i, op, a, b);
      e.res = res;
      e.rd  = rd;
      e.cyc = (l > 255) ? 8'd255 : 8'(l);
      return e;
   endfunction

   // Scoreboard: every writeback handshake must match the oldest outstanding request
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (exp_q.size() == 0) begin
            check("spurious_wb", {31'b0, wb_valid_o}, 32'd0);
         end else if (wb_valid_o && wb_ready_i) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_result", wb_result_o, e.res);
            check("wb_rd", {27'b0, wb_rd_o}, {27'b0, e.rd});
            check("div_cycles", {24'b0, div_cycles_o}, {24'b0, e.cyc});
            last_cyc = e.cyc;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rnd_wb) wb_ready_i = ($urandom_range(0, 3) != 0);
   end

   task automatic issue(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input bit push);
      bit acc = 1'b0;
      @(negedge clk);
      id_valid_i    = 1'b1;
      id_operator_i = op;
      id_op_a_i     = a;
      id_op_b_i     = b;
      id_rd_i       = rd;
      for (int i = 0; i < 1000; i++) begin
         #1;
         if (id_ready_o) begin
            if (push) exp_q.push_back(mk_exp(op, a, b, rd, res));
            @(posedge clk);
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1 id_valid_i = 1'b0;
      check("issue_accept", {31'b0, acc}, 32'd1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #2;
         if (exp_q.size() == 0 && !div_valid_o && !wb_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", {31'b0, ok}, 32'd1);
   endtask

   task automatic random_ops(input int n);
      div_opcode_e op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      for (int i = 0; i < n; i++) begin
         op = div_opcode_e'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1:       b = 32'hFFFFFFFF;
            2:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         rd = 5'($urandom_range(0, 31));
         issue(op, a, b, rd, ref_div(op, a, b), 1'b1);
      end
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      id_valid_i = 1'b0; id_operator_i = DIV_DIV; id_op_a_i = '0; id_op_b_i = '0; id_rd_i = '0;
      data_ind_timing_i = 1'b0; kill_i = 1'b0; div_ready_i = 1'b1; wb_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_id_ready", {31'b0, id_ready_o}, 32'd1);
      check("rst_div_valid", {31'b0, div_valid_o}, 32'd0);
      check("rst_div_en", {31'b0, div_en_o}, 32'd0);
      check("rst_div_ready", {31'b0, div_ready_o}, 32'd0);
      check("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
      check("rst_wb_result", wb_result_o, 32'd0);
      check("rst_wb_rd", {27'b0, wb_rd_o}, 32'd0);
      check("rst_cycles", {24'b0, div_cycles_o}, 32'd0);
      check("rst_op_a", div_op_a_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(DIV_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b1);
      drain();
      issue(DIV_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 1'b1);
      issue(DIV_DIV, 32'd1, 32'd0, 5'd7, 32'hFFFFFFFF, 1'b1);
      drain();

      // Flush on the third BUSY cycle of a long operation
      issue(DIV_DIVU, 32'h12345678, 32'd3, 5'd8, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      kill_i = 1'b1;
      #1;
      check("kill_div_valid", {31'b0, div_valid_o}, 32'd0);
      check("kill_id_ready", {31'b0, id_ready_o}, 32'd0);
      check("kill_wb_valid", {31'b0, wb_valid_o}, 32'd0);
      @(negedge clk);
      kill_i = 1'b0;
      #1;
      check("post_kill_div_valid", {31'b0, div_valid_o}, 32'd0);
      check("post_kill_idle", {31'b0, id_ready_o}, 32'd1);
      check("kill_cycles_kept", {24'b0, div_cycles_o}, {24'b0, last_cyc});
      issue(DIV_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 1'b1);
      drain();

      // Flush in the same cycle the divider reports completion
      issue(DIV_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (div_valid_i) begin
            seen = 1'b1;
            break;
         end
      end
      kill_i = 1'b1;
      #1;
      check("kill_done_seen", {31'b0, seen && div_valid_i}, 32'd1);
      @(negedge clk);
      kill_i = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      check("kill_done_cycles", {24'b0, div_cycles_o}, {24'b0, last_cyc});

      // Flush while idle blocks acceptance
      @(negedge clk);
      kill_i = 1'b1;
      id_valid_i = 1'b1;
      #1;
      check("kill_idle_ready", {31'b0, id_ready_o}, 32'd0);
      @(negedge clk);
      kill_i = 1'b0;
      id_valid_i = 1'b0;
      #1;
      check("kill_idle_no_busy", {31'b0, div_valid_o}, 32'd0);

      // Writeback backpressure with a pending request
      wb_ready_i = 1'b0;
      issue(DIV_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (wb_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("resp_reached", {31'b0, seen}, 32'd1);
      id_valid_i = 1'b1; id_operator_i = DIV_REMU; id_op_a_i = 32'd50; id_op_b_i = 32'd7; id_rd_i = 5'd9;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #2;
         check("hold_result", wb_result_o, 32'd100);
         check("hold_rd", {27'b0, wb_rd_o}, 32'd7);
         check("hold_id_ready", {31'b0, id_ready_o}, 32'd0);
         check("hold_wb_valid", {31'b0, wb_valid_o}, 32'd1);
      end
      @(negedge clk);
      wb_ready_i = 1'b1;
      exp_q.push_back(mk_exp(DIV_REMU, 32'd50, 32'd7, 5'd9, 32'd1));
      @(posedge clk);
      #1 id_valid_i = 1'b0;
      @(negedge clk);
      #2;
      check("b2b_busy", {31'b0, div_valid_o}, 32'd1);
      drain();

      // Counter saturation
      issue(DIV_DIVU, 32'h12345678, 32'd3, 5'd11, 32'h12345678 / 32'd3, 1'b1);
      drain();

      // Data-independent timing
      data_ind_timing_i = 1'b1;
      issue(DIV_DIVU, 32'hFFFFFFFF, 32'd1, 5'd12, 32'hFFFFFFFF, 1'b1);
      drain();
      issue(DIV_DIVU, 32'd5, 32'h80000000, 5'd13, 32'd0, 1'b1);
      drain();
      check("dit_cycles", {24'b0, div_cycles_o}, 32'd34);

      // Reset in the middle of an operation
      data_ind_timing_i = 1'b0;
      issue(DIV_DIVU, 32'h12345678, 32'd5, 5'd14, 32'd0, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_div_valid", {31'b0, div_valid_o}, 32'd0);
      check("mid_rst_id_ready", {31'b0, id_ready_o}, 32'd1);
      check("mid_rst_wb_result", wb_result_o, 32'd0);
      check("mid_rst_cycles", {24'b0, div_cycles_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_cyc = 8'd0;
      repeat (20) @(negedge clk);

      rnd_wb = 1'b1;
      random_ops(120);
      drain();
      rnd_wb = 1'b0;
      wb_ready_i = 1'b1;
      data_ind_timing_i = 1'b1;
      rnd_wb = 1'b1;
      random_ops(40);
      drain();
      rnd_wb = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
